// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, decoded
// opcodes and the issue-entry record carried through the skid buffer.
package alu_pkg;

    // Operand width of the datapath ALU; issue entries are sized to it.
    localparam int XLEN = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b1110;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef struct packed {
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
        logic [3:0]      ctrl;
        logic [4:0]      rd;
        logic            illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of one RV32I integer-ALU instruction into an issue
// entry (ALU control code plus x/y operands). Optional feature macro:
// ALU_ISSUE_FWD_EN adds a single forwarding source for rs1/rs2.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
`ifdef ALU_ISSUE_FWD_EN
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
`endif
    output issue_entry_t    entry
);

    localparam logic [4:0] SHIFT_AMT = 5'(SHIFT);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            is_r;
    logic            is_i;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_x;
    logic [XLEN-1:0] op_r2;
    logic [4:0]      shamt;
    logic            bad;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] op_y;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};

`ifdef ALU_ISSUE_FWD_EN
    // Select register-file or forwarded source values; x0 is never forwarded.
    always_comb begin
        op_x  = rs1_data;
        op_r2 = rs2_data;
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[19:15]))
            op_x = fwd_data;
        if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == instr[24:20]))
            op_r2 = fwd_data;
    end
`else
    logic unused_rs1_field;
    assign unused_rs1_field = ^instr[19:15];

    // Without forwarding the operands come straight from the register file.
    always_comb begin
        op_x  = rs1_data;
        op_r2 = rs2_data;
    end
`endif

    assign shamt = is_r ? op_r2[4:0] : instr[24:20];

    // Map funct3/funct7 to an ALU code and flag anything the ALU cannot do.
    always_comb begin
        bad  = !(is_r || is_i);
        ctrl = ALU_ADD;
        op_y = is_r ? op_r2 : imm;
        if (is_r && (funct7 != 7'b0000000) && (funct7 != 7'b0100000))
            bad = 1'b1;
        case (funct3)
            3'b000: begin
                ctrl = ALU_ADD;
                if (is_r && funct7[5])
                    op_y = (~op_r2) + {{(XLEN-1){1'b0}}, 1'b1};
            end
            3'b001: begin
                ctrl = ALU_SLL;
                if (shamt != SHIFT_AMT)
                    bad = 1'b1;
            end
            3'b010: ctrl = ALU_SLT;
            3'b011: bad = 1'b1;
            3'b100: ctrl = ALU_XOR;
            3'b101: begin
                ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                if (shamt != SHIFT_AMT)
                    bad = 1'b1;
            end
            3'b110: ctrl = ALU_OR;
            3'b111: ctrl = ALU_AND;
        endcase
    end

    // Illegal instructions travel as a harmless zero ADD tagged illegal.
    always_comb begin
        entry.rd      = instr[11:7];
        entry.illegal = bad;
        entry.ctrl    = bad ? ALU_ADD : ctrl;
        entry.x       = bad ? '0 : op_x;
        entry.y       = bad ? '0 : op_y;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-entry issue stage: decodes RV32I ALU instructions and buffers the
// results in a 2-entry skid FIFO whose head register drives the outputs.
// Optional feature macro: ALU_ISSUE_FWD_EN (forwarding ports fwd_*).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int SHIFT      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
`ifdef ALU_ISSUE_FWD_EN
    input  logic                  fwd_valid,
    input  logic [4:0]            fwd_rd,
    input  logic [DATA_WIDTH-1:0] fwd_data,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y,
    output logic [3:0]            ALUctrl,
    output logic [4:0]            rd,
    output logic                  illegal
);

    issue_entry_t dec;
    issue_entry_t head_q;
    issue_entry_t skid_q;
    logic [1:0]   count_q;
    logic         push;
    logic         pop;

    alu_issue_decode #(.SHIFT(SHIFT)) u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
`ifdef ALU_ISSUE_FWD_EN
        .fwd_valid(fwd_valid),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
`endif
        .entry    (dec)
    );

    // Ready and valid are decodes of the occupancy register only.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head register feeds the ALU; the skid slot absorbs one extra entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= dec;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= dec;
                    end else if (push) begin
                        skid_q  <= dec;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= skid_q;
                        if (push)
                            skid_q <= dec;
                        else
                            count_q <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign x       = head_q.x;
    assign y       = head_q.y;
    assign ALUctrl = head_q.ctrl;
    assign rd      = head_q.rd;
    assign illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: reset, decode table,
// back-pressure, sustained streaming, reset mid-stall and (with
// ALU_ISSUE_FWD_EN) operand forwarding.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  ALUctrl;
    logic [4:0]  rd;
    logic        illegal;
`ifdef ALU_ISSUE_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ex;
        logic [31:0] ey;
        logic [3:0]  ec;
        logic [4:0]  erd;
        logic        eill;
    } vec_t;

    vec_t vecs[17];

    alu_issue_stage #(.DATA_WIDTH(32), .SHIFT(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
`ifdef ALU_ISSUE_FWD_EN
        .fwd_valid(fwd_valid),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x        (x),
        .y        (y),
        .ALUctrl  (ALUctrl),
        .rd       (rd),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] stream_instr(int id);
        return {12'(id * 3), 5'd1, 3'b000, 5'(id + 1), 7'h13};
    endfunction

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=1", in_ready); end
        total++; if ({x, y} !== 64'd0) begin bad++; $display("[TB] FAIL reset_xy got=%h/%h want=0/0", x, y); end
        total++; if ({ALUctrl, rd, illegal} !== 10'd0) begin bad++; $display("[TB] FAIL reset_ctrl_rd_ill got=%h/%0d/%0b want=0/0/0", ALUctrl, rd, illegal); end
    endtask

    task automatic test_decode();
        vecs[0]  = '{{12'hFFD, 5'd1, 3'b000, 5'd5, 7'h13}, 32'd10, 32'd0, 32'd10, 32'hFFFFFFFD, 4'h2, 5'd5, 1'b0};
        vecs[1]  = '{{7'h20, 5'd2, 5'd1, 3'b000, 5'd6, 7'h33}, 32'd7, 32'd9, 32'd7, 32'hFFFFFFF7, 4'h2, 5'd6, 1'b0};
        vecs[2]  = '{{7'h20, 5'd2, 5'd1, 3'b101, 5'd7, 7'h13}, 32'h80000000, 32'd0, 32'h80000000, 32'h00000402, 4'hC, 5'd7, 1'b0};
        vecs[3]  = '{{7'h00, 5'd3, 5'd1, 3'b001, 5'd8, 7'h13}, 32'h1234, 32'd0, 32'd0, 32'd0, 4'h2, 5'd8, 1'b1};
        vecs[4]  = '{{7'h00, 5'd2, 5'd1, 3'b001, 5'd9, 7'h33}, 32'h11, 32'd2, 32'h11, 32'd2, 4'h4, 5'd9, 1'b0};
        vecs[5]  = '{{7'h00, 5'd2, 5'd1, 3'b001, 5'd10, 7'h33}, 32'h11, 32'd5, 32'd0, 32'd0, 4'h2, 5'd10, 1'b1};
        vecs[6]  = '{{7'h00, 5'd2, 5'd1, 3'b101, 5'd11, 7'h33}, 32'hF0, 32'h22, 32'hF0, 32'h22, 4'h8, 5'd11, 1'b0};
        vecs[7]  = '{{7'h00, 5'd2, 5'd1, 3'b111, 5'd12, 7'h33}, 32'hF0F0, 32'h0FF0, 32'hF0F0, 32'h0FF0, 4'h0, 5'd12, 1'b0};
        vecs[8]  = '{{7'h00, 5'd2, 5'd1, 3'b110, 5'd13, 7'h33}, 32'd1, 32'd2, 32'd1, 32'd2, 4'h1, 5'd13, 1'b0};
        vecs[9]  = '{{12'h800, 5'd1, 3'b100, 5'd14, 7'h13}, 32'd3, 32'd0, 32'd3, 32'hFFFFF800, 4'h3, 5'd14, 1'b0};
        vecs[10] = '{{7'h00, 5'd2, 5'd1, 3'b010, 5'd15, 7'h33}, 32'd5, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 4'hE, 5'd15, 1'b0};
        vecs[11] = '{{7'h00, 5'd2, 5'd1, 3'b011, 5'd16, 7'h33}, 32'd5, 32'd6, 32'd0, 32'd0, 4'h2, 5'd16, 1'b1};
        vecs[12] = '{{12'h004, 5'd1, 3'b010, 5'd17, 7'h03}, 32'd100, 32'd0, 32'd0, 32'd0, 4'h2, 5'd17, 1'b1};
        vecs[13] = '{{7'h01, 5'd2, 5'd1, 3'b000, 5'd18, 7'h33}, 32'd3, 32'd4, 32'd0, 32'd0, 4'h2, 5'd18, 1'b1};
        vecs[14] = '{{12'h7FF, 5'd1, 3'b111, 5'd19, 7'h13}, 32'd5, 32'd0, 32'd5, 32'h7FF, 4'h0, 5'd19, 1'b0};
        vecs[15] = '{{7'h00, 5'd2, 5'd1, 3'b101, 5'd20, 7'h13}, 32'd8, 32'd0, 32'd8, 32'd2, 4'h8, 5'd20, 1'b0};
        vecs[16] = '{{7'h20, 5'd2, 5'd1, 3'b101, 5'd21, 7'h33}, 32'd8, 32'd2, 32'd8, 32'd2, 4'hC, 5'd21, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].ins;
            rs1_data = vecs[i].a;
            rs2_data = vecs[i].b;
            step();
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL dec%0d_valid got=%0b want=1", i, out_valid); end
            total++; if (x !== vecs[i].ex) begin bad++; $display("[TB] FAIL dec%0d_x got=%h want=%h", i, x, vecs[i].ex); end
            total++; if (y !== vecs[i].ey) begin bad++; $display("[TB] FAIL dec%0d_y got=%h want=%h", i, y, vecs[i].ey); end
            total++; if (ALUctrl !== vecs[i].ec) begin bad++; $display("[TB] FAIL dec%0d_ctrl got=%h want=%h", i, ALUctrl, vecs[i].ec); end
            total++; if (rd !== vecs[i].erd) begin bad++; $display("[TB] FAIL dec%0d_rd got=%0d want=%0d", i, rd, vecs[i].erd); end
            total++; if (illegal !== vecs[i].eill) begin bad++; $display("[TB] FAIL dec%0d_illegal got=%0b want=%0b", i, illegal, vecs[i].eill); end
            step();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL dec_drain got=%0b want=0", out_valid); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        out_ready = 1'b0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        in_valid  = 1'b1;
        instr     = {12'h011, 5'd1, 3'b000, 5'd1, 7'h13};
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready1 got=%0b want=1", in_ready); end
        instr = {12'h022, 5'd1, 3'b000, 5'd2, 7'h13};
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready2 got=%0b want=0", in_ready); end
        instr = {12'h033, 5'd1, 3'b000, 5'd3, 7'h13};
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full%0d got=%0b want=0", k, in_ready); end
            total++; if (out_valid !== 1'b1 || rd !== 5'd1 || y !== 32'h11) begin bad++; $display("[TB] FAIL bp_hold%0d got=%0b/%0d/%h want=1/1/11", k, out_valid, rd, y); end
        end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || rd !== 5'd2 || y !== 32'h22) begin bad++; $display("[TB] FAIL bp_second got=%0b/%0d/%h want=1/2/22", out_valid, rd, y); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_after got=%0b want=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || rd !== 5'd3 || y !== 32'h33) begin bad++; $display("[TB] FAIL bp_third got=%0b/%0d/%h want=1/3/33", out_valid, rd, y); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty got=%0b want=0", out_valid); end
        total++; if (rd !== 5'd3 || y !== 32'h33) begin bad++; $display("[TB] FAIL bp_idle_hold got=%0d/%h want=3/33", rd, y); end
    endtask

    task automatic test_back_to_back();
        int expq[$];
        int next_id;
        int received;
        int gaps;
        int e;
        do_reset();
        out_ready = 1'b0;
        rs2_data  = 32'd0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            instr    = stream_instr(k);
            rs1_data = 32'h100 + k;
            step();
            expq.push_back(k);
        end
        next_id  = 2;
        received = 0;
        gaps     = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && received < 20; cyc++) begin
            if (out_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL b2b_extra got=rd%0d want=none", rd);
                end else begin
                    e = expq.pop_front();
                    total++; if (rd !== 5'(e + 1)) begin bad++; $display("[TB] FAIL b2b_rd got=%0d want=%0d", rd, e + 1); end
                    total++; if (x !== 32'h100 + e || y !== 32'(e * 3)) begin bad++; $display("[TB] FAIL b2b_xy got=%h/%h want=%h/%h", x, y, 32'h100 + e, e * 3); end
                end
                received++;
            end else begin
                gaps++;
            end
            if (next_id < 20) begin
                in_valid = 1'b1;
                instr    = stream_instr(next_id);
                rs1_data = 32'h100 + next_id;
                if (in_ready === 1'b1) begin
                    expq.push_back(next_id);
                    next_id++;
                end
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        total++; if (received != 20) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=20", received); end
        total++; if (gaps != 0) begin bad++; $display("[TB] FAIL b2b_gaps got=%0d want=0", gaps); end
        total++; if (expq.size() != 0) begin bad++; $display("[TB] FAIL b2b_left got=%0d want=0", expq.size()); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_empty got=%0b want=0", out_valid); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rs1_data  = 32'h77;
        rs2_data  = 32'h0;
        instr     = {12'h044, 5'd1, 3'b000, 5'd4, 7'h13};
        step();
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall_full got=%0b want=0", in_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_stall_hs got=%0b/%0b want=0/1", out_valid, in_ready); end
        total++; if ({x, y, ALUctrl, rd, illegal} !== 74'd0) begin bad++; $display("[TB] FAIL rst_stall_out got=%h/%h/%h/%0d/%0b want=all 0", x, y, ALUctrl, rd, illegal); end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall_noaccept got=%0b want=0", out_valid); end
    endtask

`ifdef ALU_ISSUE_FWD_EN
    task automatic test_forward();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = {7'h00, 5'd3, 5'd3, 3'b100, 5'd4, 7'h33};
        rs1_data  = 32'h11;
        rs2_data  = 32'h22;
        fwd_valid = 1'b1;
        fwd_rd    = 5'd3;
        fwd_data  = 32'h55;
        step();
        total++; if (x !== 32'h55 || y !== 32'h55 || ALUctrl !== 4'h3) begin bad++; $display("[TB] FAIL fwd_hit got=%h/%h/%h want=55/55/3", x, y, ALUctrl); end
        fwd_rd = 5'd0;
        step();
        in_valid = 1'b0;
        fwd_valid = 1'b0;
        total++; if (x !== 32'h11 || y !== 32'h22) begin bad++; $display("[TB] FAIL fwd_x0 got=%h/%h want=11/22", x, y); end
        step();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
`ifdef ALU_ISSUE_FWD_EN
        fwd_valid = 1'b0;
        fwd_rd    = 5'd0;
        fwd_data  = 32'd0;
`endif
        @(negedge clk);
        test_reset();
        test_decode();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_stall();
`ifdef ALU_ISSUE_FWD_EN
        test_forward();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-entry stage sitting directly upstream of the datapath ALU. It accepts RV32I integer-ALU instructions with register-file read data and decodes them into the ALU's 4-bit `ALUctrl` code plus `x`/`y` operands. Results are buffered in a 2-entry skid FIFO with a valid/ready handshake, so the ALU side can stall without dropping instructions. Operations the ALU cannot express are flagged illegal rather than dropped.

## Interface
- `DATA_WIDTH`, 32, operand width
- `SHIFT`, 2, the ALU's fixed shift distance; only shifts by exactly this amount are legal
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  stage can accept (buffer not full)
- `instr`  in  32  RV32I instruction word
- `rs1_data`  in  DATA_WIDTH  register-file read of rs1
- `rs2_data`  in  DATA_WIDTH  register-file read of rs2
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  ALU side consumes the head entry
- `x`  out  DATA_WIDTH  ALU operand x
- `y`  out  DATA_WIDTH  ALU operand y
- `ALUctrl`  out  4  ALU operation code
- `rd`  out  5  destination register
- `illegal`  out  1  unsupported instruction; ALU result must be discarded

## Operation
- Accept when `in_valid & in_ready`; pop when `out_valid & out_ready`.
- Opcodes 0110011 (R) and 0010011 (I) are decoded; any other opcode is illegal.
- I-type `y` is the sign-extended `instr[31:20]`. R-type `y` is `rs2_data`. `x` is always `rs1_data`.
- ALUctrl codes:
  - funct3 000: ADD = 0010.
  - R-type with funct7[5]=1 is SUB: issued as ADD with `y = ~rs2_data + 1` (two's complement, wraps mod 2^DATA_WIDTH).
  - funct3 111: AND = 0000.
  - funct3 110: OR = 0001.
  - funct3 100: XOR = 0011.
  - funct3 001: SLL = 0100.
  - funct3 101: SRL = 1000 when funct7[5]=0, SRA = 1100 when funct7[5]=1.
  - funct3 010: SLT = 1110.
- Shift legality: the shift amount (`instr[24:20]` for I-type, `rs2_data[4:0]` for R-type) must equal `SHIFT`; otherwise the instruction is illegal.
- Always illegal: funct3 011 (SLTU); R-type funct7 values other than 0000000 or 0100000.
- Illegal entries are enqueued as `illegal=1`, `ALUctrl=0010`, `x=y=0`, with `rd` kept from the instruction.
- The buffer is a 2-entry FIFO with `count` in 0..2.
- `in_ready = (count != 2)`, driven from a register with no combinational path from `out_ready`.
- Simultaneous push and pop at `count=1` or `count=2` leaves `count` unchanged and preserves order.

## Timing
- Latency: an instruction accepted at edge N is presented on the outputs from edge N+1. Throughput is 1 per cycle while `out_ready=1`.
- Outputs are registered; `x`, `y`, `ALUctrl`, `rd` and `illegal` are held stable while `out_valid & !out_ready`.
- When `out_valid=0`, outputs are held at their last values.
- Reset (any cycle, including mid-stall): `count=0`, `out_valid=0`, `in_ready=1`, `x=y=0`, `ALUctrl=0000`, `rd=0`, `illegal=0`. Buffered entries are discarded; inputs presented during the reset cycle are not accepted.

## Configuration
- `ALU_ISSUE_FWD_EN` defined adds three inputs: `fwd_valid` (1 bit), `fwd_rd` (5 bits) and `fwd_data` (DATA_WIDTH bits).
  - At accept time, if `fwd_valid` is set, `fwd_rd != 0`, and `fwd_rd` matches `instr[19:15]`, then `x` uses `fwd_data`.
  - Likewise for `instr[24:20]` and R-type `y`; for SUB the negation is applied after forwarding.
  - A forwarded `rs2` shift amount is checked for legality using `fwd_data[4:0]`.
- `ALU_ISSUE_FWD_EN` undefined: the ports are absent and operands come only from `rs1_data`/`rs2_data`.

## Structure
- Shared package `alu_pkg`:
  - ALUctrl localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_XOR`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_SLT`.
  - Opcode constants `OP_R=7'b0110011` and `OP_I=7'b0010011`.
  - Packed struct `issue_entry_t` with fields x, y, ctrl, rd, illegal.
- One sub-module `alu_issue_decode` (purely combinational: instr and operands in, `issue_entry_t` out). The top level holds the FIFO and handshake.

## Test plan
- `addi` x5,x1,-3 with `rs1_data=10` -> next cycle `x=10`, `y=0xFFFFFFFD`, `ALUctrl=0010`, `rd=5`, `illegal=0`.
- `sub` with `rs1=7`, `rs2=9` -> `ALUctrl=0010`, `y=0xFFFFFFF7`. `srai` shamt 2 -> `ALUctrl=1100`. `slli` shamt 3 -> `illegal=1`, `x=y=0`.
- Hold `out_ready=0` and push 3 back-to-back -> `in_ready` drops after 2 accepts and the third is held upstream. Release -> the 3 entries appear in order, one per cycle.
- At `count=2`, assert `out_ready=1` and `in_valid=1` every cycle -> no loss or duplication over 20 instructions, sustained 1/cycle.
- Assert `rst` mid-stall with `count=2` -> next cycle `out_valid=0`, `in_ready=1`, all outputs 0.
- With `ALU_ISSUE_FWD_EN`: `fwd_rd=3`, `fwd_data=0x55`, instr `xor` x4,x3,x3 -> `x=y=0x55`. With `fwd_rd=0` -> operands come from the register file.
